sram_rr_arbiter: RTL and testbench
==================================

Name: sram_rr_arbiter

Overview:
Shares one single-port SRAM (sp_ram-style: ADDR, D, byte-strobe write enable, Q valid one cycle after address) between NUM_REQ requesters. Each requester port can be an apb3_to_sram bridge, a DMA engine or a scrubber. The block runs round-robin arbitration with an optional per-requester lock for back-to-back bursts. It drives the SRAM control signals, returns per-requester responses one cycle after accept, and flags out-of-range addresses.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_WIDTH, 32, SRAM word width (multiple of 8)
DEPTH, 12, SRAM words (need not be power of 2)
ADDR_WIDTH, $clog2(DEPTH), word address width (localparam)
STRB_WIDTH, DATA_WIDTH/8, byte strobes (localparam)

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous active-high reset (named RST_N per codebase convention, polarity is high)
REQ_VALID  in  NUM_REQ  request valid per requester
REQ_READY  out  NUM_REQ  request accepted (one-hot or zero)
REQ_LOCK  in  NUM_REQ  hold grant after this accept
REQ_WRITE  in  NUM_REQ  1=write 0=read
REQ_ADDR  in  NUM_REQ*ADDR_WIDTH  word address, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
REQ_WDATA  in  NUM_REQ*DATA_WIDTH  write data, same packing
REQ_STRB  in  NUM_REQ*STRB_WIDTH  byte strobes, same packing
RSP_VALID  out  NUM_REQ  response strobe per requester
RSP_ERR  out  1  response is out-of-range error
RSP_RDATA  out  DATA_WIDTH  read data (shared bus, qualified by RSP_VALID)
SRAM_ADDR  out  ADDR_WIDTH  SRAM address
SRAM_CE  out  1  SRAM access enable
SRAM_WE  out  STRB_WIDTH  byte write enables
SRAM_WDATA  out  DATA_WIDTH  write data
SRAM_RDATA  in  DATA_WIDTH  SRAM Q, valid the cycle after a read access

Behaviour:
- Reset (RST_N=1 at a CLK edge): rr_ptr=0, lock_valid=0, rsp_pend=0. Next cycle RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0. Any in-flight response is dropped. REQ_READY=0 and SRAM_CE=0 while RST_N is high.
- Grant is combinational. If lock_valid=1 and REQ_VALID[lock_id]=1, g=lock_id. Otherwise g is the first i with REQ_VALID[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ. No valid request: REQ_READY=0, SRAM_CE=0, SRAM_WE=0.
- Accept: REQ_READY[g]=1 in the same cycle, so a request is accepted when VALID&READY. One accept per cycle max; throughput is 1 access/cycle.
- SRAM drive in the accept cycle: SRAM_ADDR=REQ_ADDR[g]. SRAM_WDATA=REQ_WDATA[g].
  - Write: SRAM_WE=REQ_STRB[g]; a write with strobes all zero still accepts and acks.
  - Read: SRAM_WE=0.
  - SRAM_CE=1 only if REQ_ADDR[g] < DEPTH.
- Out of range (addr >= DEPTH): accept anyway, SRAM_CE=0, SRAM_WE=0. Response carries RSP_ERR=1 and RSP_RDATA=0.
- Response: exactly one cycle after accept, RSP_VALID[g]=1 for one cycle. Read: RSP_RDATA=SRAM_RDATA. Write: RSP_RDATA=0, and the response is an ack. Response order equals accept order; there is no backpressure on responses.
- rr_ptr update on accept: rr_ptr <= (g+1) mod NUM_REQ, unless the accept is a locked continuation; then rr_ptr is unchanged.
- Lock:
  - On accept with REQ_LOCK[g]=1: lock_valid<=1, lock_id<=g.
  - On accept with REQ_LOCK[g]=0: lock_valid<=0.
  - If the lock owner deasserts REQ_VALID, lock_valid clears that cycle and normal round-robin resumes the same cycle.
  - Lock is limited to 16 consecutive accepts (lock_cnt). The 16th forces lock_valid<=0 and rr_ptr<=lock_id+1.
- Simultaneous request from all ports with rr_ptr=k: grant order k, k+1, ... wraps; each port waits at most NUM_REQ-1 cycles (absent locks).
- Requester rule: hold VALID and payload stable until READY. The arbiter does not check this.

Decomposition:
- Package sram_arb_pkg holds:
  - LOCK_MAX=16
  - function rr_pick(valid, ptr) returning index+found
  - typedef rsp_t {valid_id, err, is_read}
- Sub-module rr_priority_pick (NUM_REQ) holds the combinational rotate-priority select and is reused by future bus arbiters.
- Top holds the lock FSM (UNLOCKED/LOCKED), rr_ptr, lock_cnt and the response pipeline register.

Test Plan:
- Single read: preload addr 3 with 0xDEADBEEF; port0 reads addr 3 -> READY[0] same cycle, SRAM_CE=1, SRAM_ADDR=3; next cycle RSP_VALID=01, RSP_RDATA=0xDEADBEEF, RSP_ERR=0.
- Fairness: ports 0,1 both VALID for 6 cycles from reset -> grants 0,1,0,1,0,1; each RSP_VALID one cycle later.
- Byte write: port1 writes 0x11223344 strb 4'b0101 to addr 5 holding 0xFFFFFFFF, then reads -> SRAM_WE=0101, readback 0xFF22FF44, write ack RSP_RDATA=0.
- Out of range: port0 reads addr 12 (DEPTH=12) -> SRAM_CE=0, next cycle RSP_VALID=01, RSP_ERR=1, RSP_RDATA=0.
- Lock burst: port0 LOCK=1 VALID for 20 cycles, port1 VALID throughout -> port0 gets 16 consecutive grants, then port1 is granted, then port0.
- Reset mid-op: assert RST_N the cycle after a read accept -> no RSP_VALID; after release rr_ptr=0 and port0 is granted first.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM round-robin arbiter and related bus arbiters.
package sram_arb_pkg;

    localparam int unsigned LOCK_MAX  = 16;
    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned MAX_IDX_W = 3;

    typedef struct packed {
        logic                 found;
        logic [MAX_IDX_W-1:0] idx;
    } pick_t;

    typedef struct packed {
        logic [MAX_REQ-1:0] valid_id;
        logic               err;
        logic               is_read;
    } rsp_t;

    // First set bit of valid scanning ptr, ptr+1, ... wrapping at num (ptr < num assumed).
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                      input logic [MAX_IDX_W-1:0] ptr,
                                      input int unsigned          num);
        pick_t                res;
        int unsigned          s;
        logic [MAX_IDX_W-1:0] cand;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            s = 32'(ptr) + k;
            if (s >= num) begin
                s = s - num;
            end
            cand = MAX_IDX_W'(s);
            if (k < num && !res.found && valid[cand]) begin
                res.found = 1'b1;
                res.idx   = cand;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority select: first valid requester at or after ptr_i.
module rr_priority_pick
    import sram_arb_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    localparam int unsigned IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic [NumReq-1:0] valid_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic              found_o,
    output logic [IdxW-1:0]   idx_o
);

    pick_t pick;

    always_comb begin
        pick    = rr_pick(MAX_REQ'(valid_i), MAX_IDX_W'(ptr_i), NumReq);
        found_o = pick.found;
        idx_o   = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            if (pick.idx == MAX_IDX_W'(i)) begin
                idx_o = IdxW'(i);
            end
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters,
// with per-requester burst lock and a one-cycle response pipeline.
module sram_rr_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 12,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH),
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [NUM_REQ-1:0]             REQ_VALID,
    output logic [NUM_REQ-1:0]             REQ_READY,
    input  logic [NUM_REQ-1:0]             REQ_LOCK,
    input  logic [NUM_REQ-1:0]             REQ_WRITE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  REQ_WDATA,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]  REQ_STRB,
    output logic [NUM_REQ-1:0]             RSP_VALID,
    output logic                           RSP_ERR,
    output logic [DATA_WIDTH-1:0]          RSP_RDATA,
    output logic [ADDR_WIDTH-1:0]          SRAM_ADDR,
    output logic                           SRAM_CE,
    output logic [STRB_WIDTH-1:0]          SRAM_WE,
    output logic [DATA_WIDTH-1:0]          SRAM_WDATA,
    input  logic [DATA_WIDTH-1:0]          SRAM_RDATA
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {StUnlocked, StLocked} lock_state_e;

    lock_state_e     state_q, state_d;
    logic [IdxW-1:0] lock_id_q, lock_id_d;
    logic [4:0]      lock_cnt_q, lock_cnt_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    rsp_t            rsp_q, rsp_d;

    logic                  pick_found;
    logic [IdxW-1:0]       pick_idx;
    logic                  lock_valid, locked_hit, accept, in_range, write_g;
    logic [IdxW-1:0]       g;
    logic [ADDR_WIDTH-1:0] addr_g;
    logic [STRB_WIDTH-1:0] strb_g;
    logic [NUM_REQ-1:0]    grant_oh;
    logic                  rsp_live;

    function automatic logic [IdxW-1:0] inc_ptr(input logic [IdxW-1:0] p);
        if (32'(p) == NUM_REQ - 1) begin
            return '0;
        end
        return p + IdxW'(1);
    endfunction

    rr_priority_pick #(
        .NumReq (NUM_REQ)
    ) u_pick (
        .valid_i (REQ_VALID),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            state_q    <= StUnlocked;
            lock_id_q  <= '0;
            lock_cnt_q <= '0;
            rr_ptr_q   <= '0;
            rsp_q      <= '0;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            lock_cnt_q <= lock_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_q      <= rsp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        lock_cnt_d = lock_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        if (accept) begin
            if (locked_hit) begin
                // Locked continuation keeps rr_ptr unless the burst cap is hit.
                lock_cnt_d = lock_cnt_q + 5'd1;
                if (lock_cnt_d == 5'(LOCK_MAX)) begin
                    state_d  = StUnlocked;
                    rr_ptr_d = inc_ptr(lock_id_q);
                end else if (!REQ_LOCK[g]) begin
                    state_d = StUnlocked;
                end
            end else begin
                rr_ptr_d = inc_ptr(g);
                if (REQ_LOCK[g]) begin
                    state_d    = StLocked;
                    lock_id_d  = g;
                    lock_cnt_d = 5'd1;
                end else begin
                    state_d = StUnlocked;
                end
            end
        end else begin
            state_d = StUnlocked;
        end
    end

    always_comb begin
        lock_valid = (state_q == StLocked);
        locked_hit = lock_valid && REQ_VALID[lock_id_q];
        g          = locked_hit ? lock_id_q : pick_idx;
        accept     = !RST_N && (locked_hit || pick_found);
        addr_g     = REQ_ADDR[g*ADDR_WIDTH +: ADDR_WIDTH];
        strb_g     = REQ_STRB[g*STRB_WIDTH +: STRB_WIDTH];
        write_g    = REQ_WRITE[g];
        in_range   = {1'b0, addr_g} < (ADDR_WIDTH+1)'(DEPTH);
        grant_oh   = accept ? (NUM_REQ'(1) << g) : '0;

        REQ_READY  = grant_oh;
        SRAM_ADDR  = addr_g;
        SRAM_WDATA = REQ_WDATA[g*DATA_WIDTH +: DATA_WIDTH];
        SRAM_CE    = accept && in_range;
        SRAM_WE    = (accept && in_range && write_g) ? strb_g : '0;

        rsp_d.valid_id = MAX_REQ'(grant_oh);
        rsp_d.err      = !in_range;
        rsp_d.is_read  = !write_g;

        // Reset hides a response already in the pipeline.
        rsp_live  = !RST_N && (|rsp_q.valid_id);
        RSP_VALID = RST_N ? '0 : rsp_q.valid_id[NUM_REQ-1:0];
        RSP_ERR   = rsp_live && rsp_q.err;
        RSP_RDATA = (rsp_live && rsp_q.is_read && !rsp_q.err) ? SRAM_RDATA : '0;
    end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed self-checking bench for sram_rr_arbiter with a behavioural single-port SRAM.
module tb_sram_rr_arbiter;

    localparam int unsigned NR    = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 12;
    localparam int unsigned AW    = 4;
    localparam int unsigned SW    = 4;

    logic            CLK = 1'b0;
    logic            RST_N;
    logic [NR-1:0]   req_valid, req_ready, req_lock, req_write, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR*SW-1:0] req_strb;
    logic            rsp_err;
    logic [DW-1:0]   rsp_rdata, sram_wdata, sram_rdata;
    logic [AW-1:0]   sram_addr;
    logic            sram_ce;
    logic [SW-1:0]   sram_we;

    logic            pre_en;
    logic [AW-1:0]   pre_addr;
    logic [DW-1:0]   pre_data;
    logic [DW-1:0]   mem [0:15];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    sram_rr_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .REQ_VALID  (req_valid),
        .REQ_READY  (req_ready),
        .REQ_LOCK   (req_lock),
        .REQ_WRITE  (req_write),
        .REQ_ADDR   (req_addr),
        .REQ_WDATA  (req_wdata),
        .REQ_STRB   (req_strb),
        .RSP_VALID  (rsp_valid),
        .RSP_ERR    (rsp_err),
        .RSP_RDATA  (rsp_rdata),
        .SRAM_ADDR  (sram_addr),
        .SRAM_CE    (sram_ce),
        .SRAM_WE    (sram_we),
        .SRAM_WDATA (sram_wdata),
        .SRAM_RDATA (sram_rdata)
    );

    // sp_ram model: byte-strobed write, Q registered one cycle after a read access.
    always @(posedge CLK) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (sram_ce) begin
            if (sram_we != '0) begin
                for (int b = 0; b < SW; b++) begin
                    if (sram_we[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
                end
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic clear_inputs();
        req_valid = '0;
        req_lock  = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST_N = 1'b1;
        clear_inputs();
        @(posedge CLK); #1;
        RST_N = 1'b0;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge CLK); #1;
        pre_en   = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b00) begin
            bad++; $display("FAIL rst_ready got=%b exp=00", req_ready);
        end
        total++;
        if (sram_ce !== 1'b0) begin
            bad++; $display("FAIL rst_ce got=%b exp=0", sram_ce);
        end
        @(posedge CLK); #1;
        RST_N = 1'b0;
        clear_inputs();
        #1;
        total++;
        if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL rst_rsp got=%b/%b/%h exp=00/0/00000000",
                            rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_single_read();
        preload(4'd3, 32'hDEAD_BEEF);
        req_valid     = 2'b01;
        req_addr[3:0] = 4'd3;
        #1;
        total++;
        if (req_ready !== 2'b01 || sram_ce !== 1'b1 || sram_addr !== 4'd3 || sram_we !== 4'h0)
        begin
            bad++; $display("FAIL rd_accept got=rdy%b ce%b a%h we%h exp=rdy01 ce1 a3 we0",
                            req_ready, sram_ce, sram_addr, sram_we);
        end
        @(posedge CLK); #1;
        clear_inputs();
        total++;
        if (rsp_valid !== 2'b01) begin
            bad++; $display("FAIL rd_rsp_valid got=%b exp=01", rsp_valid);
        end
        total++;
        if (rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
            bad++; $display("FAIL rd_rsp_data got=%h err%b exp=deadbeef err0", rsp_rdata, rsp_err);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_fairness();
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] prev;
        do_reset();
        prev          = 2'b00;
        req_valid     = 2'b11;
        req_addr[3:0] = 4'd0;
        req_addr[7:4] = 4'd1;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
            total++;
            if (req_ready !== exp_rdy) begin
                bad++; $display("FAIL fair_grant[%0d] got=%b exp=%b", i, req_ready, exp_rdy);
            end
            total++;
            if (rsp_valid !== prev) begin
                bad++; $display("FAIL fair_rsp[%0d] got=%b exp=%b", i, rsp_valid, prev);
            end
            prev = exp_rdy;
            @(posedge CLK); #1;
        end
        clear_inputs();
        #1;
        total++;
        if (rsp_valid !== 2'b10) begin
            bad++; $display("FAIL fair_rsp_last got=%b exp=10", rsp_valid);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_byte_write();
        preload(4'd5, 32'hFFFF_FFFF);
        req_valid        = 2'b10;
        req_write        = 2'b10;
        req_addr[7:4]    = 4'd5;
        req_wdata[63:32] = 32'h1122_3344;
        req_strb[7:4]    = 4'b0101;
        #1;
        total++;
        if (req_ready !== 2'b10 || sram_ce !== 1'b1 || sram_we !== 4'b0101 ||
            sram_wdata !== 32'h1122_3344 || sram_addr !== 4'd5) begin
            bad++; $display("FAIL bw_drive got=rdy%b ce%b we%b wd%h a%h exp=rdy10 ce1 we0101 wd11223344 a5",
                            req_ready, sram_ce, sram_we, sram_wdata, sram_addr);
        end
        @(posedge CLK); #1;
        req_write = 2'b00;
        #1;
        total++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL bw_ack got=%b/%h/%b exp=10/00000000/0",
                            rsp_valid, rsp_rdata, rsp_err);
        end
        total++;
        if (req_ready !== 2'b10 || sram_we !== 4'h0) begin
            bad++; $display("FAIL bw_readback_drive got=rdy%b we%b exp=rdy10 we0000",
                            req_ready, sram_we);
        end
        @(posedge CLK); #1;
        clear_inputs();
        total++;
        if (rsp_valid !== 2'b10 || rsp_rdata !== 32'hFF22_FF44) begin
            bad++; $display("FAIL bw_readback got=%b/%h exp=10/ff22ff44", rsp_valid, rsp_rdata);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_out_of_range();
        req_valid     = 2'b01;
        req_addr[3:0] = 4'd12;
        #1;
        total++;
        if (req_ready !== 2'b01 || sram_ce !== 1'b0) begin
            bad++; $display("FAIL oor_rd_drive got=rdy%b ce%b exp=rdy01 ce0", req_ready, sram_ce);
        end
        @(posedge CLK); #1;
        req_write       = 2'b01;
        req_addr[3:0]   = 4'd15;
        req_strb[3:0]   = 4'hF;
        req_wdata[31:0] = 32'hA5A5_A5A5;
        #1;
        total++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL oor_rd_rsp got=%b/%b/%h exp=01/1/00000000",
                            rsp_valid, rsp_err, rsp_rdata);
        end
        total++;
        if (req_ready !== 2'b01 || sram_ce !== 1'b0 || sram_we !== 4'h0) begin
            bad++; $display("FAIL oor_wr_drive got=rdy%b ce%b we%b exp=rdy01 ce0 we0000",
                            req_ready, sram_ce, sram_we);
        end
        @(posedge CLK); #1;
        clear_inputs();
        total++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL oor_wr_rsp got=%b/%b/%h exp=01/1/00000000",
                            rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge CLK); #1;
        total++;
        if (rsp_valid !== 2'b00 || rsp_err !== 1'b0) begin
            bad++; $display("FAIL oor_idle got=%b/%b exp=00/0", rsp_valid, rsp_err);
        end
    endtask

    task automatic test_lock_burst();
        logic [NR-1:0] exp_rdy;
        do_reset();
        req_valid = 2'b11;
        req_lock  = 2'b01;
        for (int i = 0; i < 20; i++) begin
            #1;
            exp_rdy = (i == 16) ? 2'b10 : 2'b01;
            total++;
            if (req_ready !== exp_rdy) begin
                bad++; $display("FAIL lock_grant[%0d] got=%b exp=%b", i, req_ready, exp_rdy);
            end
            @(posedge CLK); #1;
        end
        // Owner still locked; dropping its VALID hands the slot to port1 at once.
        req_valid = 2'b10;
        #1;
        total++;
        if (req_ready !== 2'b10) begin
            bad++; $display("FAIL lock_drop got=%b exp=10", req_ready);
        end
        @(posedge CLK); #1;
        clear_inputs();
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req_valid     = 2'b01;
        req_addr[3:0] = 4'd3;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL mid_accept got=%b exp=01", req_ready);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        clear_inputs();
        #1;
        total++;
        if (rsp_valid !== 2'b00 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL mid_rsp_dropped got=%b/%h exp=00/00000000", rsp_valid, rsp_rdata);
        end
        @(posedge CLK); #1;
        RST_N     = 1'b0;
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b01) begin
            bad++; $display("FAIL post_rst_grant got=%b exp=01", req_ready);
        end
        total++;
        if (rsp_valid !== 2'b00) begin
            bad++; $display("FAIL post_rst_rsp got=%b exp=00", rsp_valid);
        end
        @(posedge CLK); #1;
        clear_inputs();
        @(posedge CLK); #1;
    endtask

    initial begin
        RST_N    = 1'b1;
        pre_en   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        clear_inputs();
        @(posedge CLK); #1;
        test_reset();
        test_single_read();
        test_fairness();
        test_byte_write();
        test_out_of_range();
        test_lock_burst();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
